// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first,
// with a valid/ready handshake on both the operand and the result side.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // dividend shift register, MSB consumed first
  logic [WIDTH-1:0]   dvs_q, dvs_d;   // captured divisor
  logic [WIDTH-1:0]   rem_q, rem_d;   // working partial remainder
  logic [WIDTH-1:0]   acc_q, acc_d;   // working quotient
  logic [WIDTH-1:0]   quo_q, quo_d;   // published quotient
  logic [WIDTH-1:0]   rmo_q, rmo_d;   // published remainder
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     partial;
  logic               step_bit;
  logic [WIDTH-1:0]   step_rem;
  logic [WIDTH-1:0]   step_quo;

  // One restoring step; the difference always fits in WIDTH bits when taken.
  always_comb begin
    partial  = {rem_q, dvd_q[WIDTH-1]};
    step_bit = (partial >= {1'b0, dvs_q});
    step_rem = step_bit ? WIDTH'(partial - {1'b0, dvs_q}) : partial[WIDTH-1:0];
    step_quo = {acc_q[WIDTH-2:0], step_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      quo_q   <= '0;
      rmo_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      rmo_q   <= rmo_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    rmo_d   = rmo_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          dvd_d = in1;
          dvs_d = in2;
          rem_d = '0;
          acc_d = '0;
          // Zero divisor bypasses the iteration and publishes the fixed result.
          if (in2 == '0) begin
            quo_d   = '1;
            rmo_d   = in1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        rem_d = step_rem;
        acc_d = step_quo;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quo_d   = step_quo;
          rmo_d   = step_rem;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the dividend, divisor, quotient and remainder width; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in1, input, WIDTH, unsigned dividend.
REQ-005 SHALL have port in2, input, WIDTH, unsigned divisor.
REQ-006 SHALL have port in_valid, input, 1, operand request.
REQ-007 SHALL have port in_ready, output, 1, block can accept operands.
REQ-008 SHALL have port out_valid, output, 1, result available.
REQ-009 SHALL have port out_ready, input, 1, consumer takes result.
REQ-010 SHALL have port quotient, output, WIDTH, registered quotient.
REQ-011 SHALL have port remainder, output, WIDTH, registered remainder.
REQ-012 SHALL have port div_by_zero, output, 1, flags that the current result came from in2 == 0.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready = 1 exactly when the state is IDLE, and out_valid = 1 exactly when the state is DONE.
REQ-015 Acceptance SHALL occur on a rising edge with in_valid & in_ready; in1 and in2 SHALL be captured on that edge, and later changes to them SHALL be ignored.
REQ-016 On acceptance with in2 != 0, the FSM SHALL go IDLE -> CALC with the iteration counter at 0.
REQ-017 In CALC, each cycle SHALL perform one restoring-division step, MSB first:
- partial remainder (WIDTH+1 bits) = {rem, next dividend bit};
- if the partial remainder >= divisor, subtract the divisor and shift 1 into the quotient; otherwise shift 0.
REQ-018 After exactly WIDTH CALC cycles, the FSM SHALL enter DONE; out_valid SHALL rise on the edge WIDTH cycles after the acceptance edge.
REQ-019 Results SHALL satisfy in1 == quotient*in2 + remainder, with remainder < in2 (unsigned, no overflow possible).
REQ-020 On acceptance with in2 == 0, the FSM SHALL go IDLE -> DONE on the next edge (latency 1) with:
- quotient = all ones;
- remainder = captured in1;
- div_by_zero = 1.
REQ-021 div_by_zero SHALL be 0 for every result with in2 != 0.
REQ-022 In DONE, quotient, remainder and div_by_zero SHALL stay stable while out_ready = 0, for any number of cycles.
REQ-023 On an edge with out_valid & out_ready, the FSM SHALL return DONE -> IDLE; in_ready SHALL rise in the following cycle (no same-cycle release-and-accept).
REQ-024 in_valid SHALL be ignored in CALC and DONE; no operand SHALL be queued.
REQ-025 quotient and remainder outputs SHALL show the last completed result, or zero after reset; intermediate CALC values SHALL NOT be visible on them.
REQ-026 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL be cleared on every acceptance.

Reset
REQ-027 When rst_n = 0, the block SHALL immediately (asynchronously) enter IDLE and clear the counter, quotient, remainder, div_by_zero and all internal datapath registers to 0.
REQ-028 During and after reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-029 Reset asserted in CALC or DONE SHALL abort the operation with no result delivered; the first operation after rst_n rises SHALL produce a correct result.
REQ-030 Deassertion of rst_n SHALL be synchronised externally; the block SHALL accept operands on the first clk edge after rst_n rises.

Verification
REQ-031 WIDTH=8, in1=200, in2=7, one-cycle in_valid -> out_valid 8 cycles after acceptance with quotient=28, remainder=4, div_by_zero=0.
REQ-032 in1=5, in2=0 -> out_valid 1 cycle after acceptance with quotient=255, remainder=5, div_by_zero=1.
REQ-033 Boundary operands, each checked for quotient and remainder:
- 255/1 -> 255 r 0;
- 3/10 -> 0 r 3;
- 0/9 -> 0 r 0;
- 255/255 -> 1 r 0.
REQ-034 Result 100/3 with out_ready held 0 for 5 cycles -> quotient=33, remainder=1 stable throughout; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-035 Reset mid-operation: rst_n low 4 cycles into 200/7 -> all outputs 0 immediately, in_ready=1; a following 77/5 -> 15 r 2.
REQ-036 Random: 10000 random operand pairs with random in_valid/out_ready gaps -> every result matches the reference model, and exactly one out_valid handshake per acceptance.
